decoder: RTL and testbench

//  ASCII command parser between the UART receiver and the calculator ALU.

---
 rtl/calc_pkg.sv | 52 +++++
 rtl/dec_accum.sv | 58 +++++
 rtl/decoder.sv | 143 ++++++++++++++
 tb/tb_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command path: ASCII codes, type and
// operator encodings, and the parser state enum.
package calc_pkg;

    localparam logic [7:0] CH_I     = 8'h49;
    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_U     = 8'h55;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_DIV   = 8'h2F;
    localparam logic [7:0] CH_MOD   = 8'h25;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    localparam logic [3:0] DT_SINT = 4'b0101;
    localparam logic [3:0] DT_UINT = 4'b0110;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b01000;
    localparam logic [4:0] OP_MOD = 5'b10000;

    localparam logic [2:0] MAX_DIGITS = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_SRC1,
        ST_SRC2,
        ST_DONE
    } state_e;

    // Zero when the byte is not an operator character.
    function automatic logic [4:0] op_onehot(input logic [7:0] ch);
        logic [4:0] oh;
        oh = '0;
        case (ch)
            CH_PLUS:  oh = OP_ADD;
            CH_MINUS: oh = OP_SUB;
            CH_MUL:   oh = OP_MUL;
            CH_DIV:   oh = OP_DIV;
            CH_MOD:   oh = OP_MOD;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/dec_accum.sv
// 16-bit decimal operand accumulator: clear, shift-in one digit, sign flag
// applied on read, and a digit counter for the operand length limit.
module dec_accum
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [3:0]  digit_i,
    input  logic        neg_i,
    output logic [15:0] value_o,
    output logic        neg_o,
    output logic        any_o,
    output logic        full_o
);

    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
            neg_d = 1'b0;
        end else begin
            if (load_i) begin
                acc_d = acc_q * 16'd10 + {12'd0, digit_i};
                cnt_d = cnt_q + 3'd1;
            end
            if (neg_i) begin
                neg_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
        end
    end

    assign value_o = neg_q ? (~acc_q + 16'd1) : acc_q;
    assign neg_o   = neg_q;
    assign any_o   = (cnt_q != 3'd0);
    assign full_o  = (cnt_q == MAX_DIGITS);

endmodule

// File: rtl/decoder.sv
// ASCII command parser: turns "I<S|U> <num1><op><num2>=" into a registered
// type/operator/operand set with a one-cycle parser_done pulse.
module decoder
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  data,
    input  logic        data_valid,
    output logic [3:0]  dtype,
    output logic [4:0]  operator,
    output logic [15:0] src1,
    output logic [15:0] src2,
    output logic        parser_done
);

    state_e      state_q, state_d;
    logic        sgn_q;
    logic [4:0]  op_q;
    logic [3:0]  dtype_q;
    logic [4:0]  op_out_q;
    logic [15:0] src1_q, src2_q;

    logic        byte_v, is_dig, minus1_ok, minus2_ok;
    logic [4:0]  opc;
    logic        clr, err, ld1, ld2, neg1_set, neg2_set, op_ld, type_ld, out_ld;
    logic [15:0] val1, val2;
    logic        neg1, neg2, any1, any2, full1, full2;

    assign byte_v    = data_valid && (data != CH_SP);
    assign is_dig    = (data >= CH_0) && (data <= CH_9);
    assign opc       = op_onehot(data);
    assign minus1_ok = (data == CH_MINUS) && sgn_q && !any1 && !neg1;
    assign minus2_ok = (data == CH_MINUS) && sgn_q && !any2 && !neg2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE behaves like IDLE for the incoming byte so an 'I' right after '=' is taken.
    always_comb begin
        state_d = state_q;
        if (byte_v) begin
            case (state_q)
                ST_IDLE, ST_DONE: state_d = (data == CH_I) ? ST_TYPE : ST_IDLE;
                ST_TYPE:          state_d = (data == CH_S || data == CH_U) ? ST_SRC1 : ST_IDLE;
                ST_SRC1: begin
                    if (is_dig && !full1)          state_d = ST_SRC1;
                    else if (minus1_ok)            state_d = ST_SRC1;
                    else if (opc != '0 && any1)    state_d = ST_SRC2;
                    else                           state_d = ST_IDLE;
                end
                ST_SRC2: begin
                    if (is_dig && !full2)          state_d = ST_SRC2;
                    else if (minus2_ok)            state_d = ST_SRC2;
                    else if (data == CH_EQ && any2) state_d = ST_DONE;
                    else                           state_d = ST_IDLE;
                end
                default:          state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        err      = byte_v && (state_d == ST_IDLE) &&
                   (state_q == ST_TYPE || state_q == ST_SRC1 || state_q == ST_SRC2);
        clr      = err || (state_q == ST_IDLE) || (state_q == ST_DONE);
        ld1      = byte_v && (state_q == ST_SRC1) && is_dig && !full1;
        ld2      = byte_v && (state_q == ST_SRC2) && is_dig && !full2;
        neg1_set = byte_v && (state_q == ST_SRC1) && minus1_ok;
        neg2_set = byte_v && (state_q == ST_SRC2) && minus2_ok;
        type_ld  = byte_v && (state_q == ST_TYPE) && (state_d == ST_SRC1);
        op_ld    = byte_v && (state_q == ST_SRC1) && (state_d == ST_SRC2);
        out_ld   = byte_v && (state_q == ST_SRC2) && (state_d == ST_DONE);
        parser_done = (state_q == ST_DONE);
    end

    dec_accum u_acc1 (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr_i   (clr),
        .load_i  (ld1),
        .digit_i (data[3:0]),
        .neg_i   (neg1_set),
        .value_o (val1),
        .neg_o   (neg1),
        .any_o   (any1),
        .full_o  (full1)
    );

    dec_accum u_acc2 (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr_i   (clr),
        .load_i  (ld2),
        .digit_i (data[3:0]),
        .neg_i   (neg2_set),
        .value_o (val2),
        .neg_o   (neg2),
        .any_o   (any2),
        .full_o  (full2)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sgn_q <= 1'b0;
            op_q  <= '0;
        end else if (clr) begin
            sgn_q <= 1'b0;
            op_q  <= '0;
        end else begin
            if (type_ld) sgn_q <= (data == CH_S);
            if (op_ld)   op_q  <= opc;
        end
    end

    // Published results change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dtype_q  <= '0;
            op_out_q <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
        end else if (out_ld) begin
            dtype_q  <= sgn_q ? DT_SINT : DT_UINT;
            op_out_q <= op_q;
            src1_q   <= val1;
            src2_q   <= val2;
        end
    end

    assign dtype    = dtype_q;
    assign operator = op_out_q;
    assign src1     = src1_q;
    assign src2     = src2_q;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for the ASCII command decoder.
module tb_decoder;

    typedef struct packed {
        logic [3:0]  dt;
        logic [4:0]  op;
        logic [15:0] s1;
        logic [15:0] s2;
    } cmd_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  data;
    logic        data_valid;
    logic [3:0]  dtype;
    logic [4:0]  operator;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        parser_done;

    cmd_t q[$];
    cmd_t last_exp;
    int   n_chk = 0;
    int   n_bad = 0;
    int   got_done = 0;
    int   exp_done = 0;
    int   run = 0;

    decoder dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .data        (data),
        .data_valid  (data_valid),
        .dtype       (dtype),
        .operator    (operator),
        .src1        (src1),
        .src2        (src2),
        .parser_done (parser_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_cmd(input logic [3:0] dt, input logic [4:0] op,
                              input logic [15:0] s1, input logic [15:0] s2);
        cmd_t c;
        c.dt = dt; c.op = op; c.s1 = s1; c.s2 = s2;
        q.push_back(c);
        last_exp = c;
        exp_done++;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            data       = s[i];
            data_valid = 1'b1;
        end
        @(negedge clk);
        data_valid = 1'b0;
        data       = 8'h00;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_drain"}, q.size(), 0);
    endtask

    task automatic check_outs(input string tag, input cmd_t e);
        chk({tag, "_dtype"}, {28'd0, dtype}, {28'd0, e.dt});
        chk({tag, "_op"},    {27'd0, operator}, {27'd0, e.op});
        chk({tag, "_src1"},  {16'd0, src1}, {16'd0, e.s1});
        chk({tag, "_src2"},  {16'd0, src2}, {16'd0, e.s2});
    endtask

    always @(negedge clk) begin
        if (n_rst && parser_done) begin
            cmd_t e;
            got_done++;
            run++;
            chk("done_width", run, 1);
            if (q.size() == 0) begin
                chk("unexp_done", got_done, exp_done);
            end else begin
                e = q.pop_front();
                check_outs("cmd", e);
            end
        end else begin
            run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string idle_s;
        logic [7:0] ch;
        idle_s     = "IS1+1=";
        n_rst      = 1'b0;
        data_valid = 1'b0;
        data       = 8'h00;
        last_exp   = '0;
        repeat (3) @(negedge clk);
        check_outs("rst", '0);
        chk("rst_done", {31'd0, parser_done}, 0);
        n_rst = 1'b1;
        @(negedge clk);

        expect_cmd(4'b0101, 5'b00001, 16'h04D2, 16'h162E);
        send("IS 1234+5678=");
        drain("add");

        expect_cmd(4'b0110, 5'b00100, 16'hFFFF, 16'h0002);
        send("IU 65535*2=");
        drain("mul");

        expect_cmd(4'b0110, 5'b01000, 16'h869F, 16'h0003);
        send("IU 99999/3=");
        drain("wrap");

        expect_cmd(4'b0101, 5'b00010, 16'hFFF4, 16'hFFFD);
        send("IS -12- -3=");
        drain("neg");

        send("IU -5+1=");
        repeat (3) @(negedge clk);
        check_outs("uneg_err", last_exp);

        send("IS 12X");
        expect_cmd(4'b0101, 5'b10000, 16'h0007, 16'h0002);
        send("IS 7%2=");
        drain("mod");

        send("IU 123456+1=");
        repeat (3) @(negedge clk);
        check_outs("six_dig", last_exp);

        send("IS --3+1=");
        send("IS 3+=");
        repeat (3) @(negedge clk);
        check_outs("bad_minus", last_exp);

        expect_cmd(4'b0101, 5'b00001, 16'h0001, 16'h0002);
        expect_cmd(4'b0110, 5'b00010, 16'h9C40, 16'h0001);
        send("IS 1+2=IU 40000-1=");
        drain("b2b");

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            ch         = idle_s[i % 6];
            data       = ch;
            data_valid = 1'b0;
        end
        @(negedge clk);
        data = 8'h00;
        check_outs("idle", last_exp);

        expect_cmd(4'b0101, 5'b00001, 16'h8000, 16'h7FFF);
        send("IS -32768+32767=");
        drain("smax");

        send("IS 12+");
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        last_exp = '0;
        check_outs("mid_rst", last_exp);
        chk("mid_rst_done", {31'd0, parser_done}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        expect_cmd(4'b0101, 5'b00001, 16'h0003, 16'h0004);
        send("IS 3+4=");
        drain("after_rst");

        repeat (5) @(negedge clk);
        chk("done_total", got_done, exp_done);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
